// File: rtl/id_ex_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_pkg
//
// Shared pipeline definitions used by decode/control and the ID/EX register:
//   - base opcode constants used by the main control decoder
//   - alu_op class encodings handed from control to ALU control
//   - the packed control bundle carried down the pipeline
//   - BUBBLE_CTRL, the all-zero bundle that makes an entry a no-op
// ---------------------------------------------------------------------------
package id_ex_stage_reg_pkg;

    // Base opcodes recognised by the main control decoder
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU op class: add for address generation, subtract for branch
    // compare, or decode funct fields
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    // Control bundle, most significant field first
    typedef struct packed {
        logic       branch;
        logic       reg_write;
        logic       memto_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // A bubble carries no side effects: no write-back, no memory access,
    // no branch.
    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Event counter that sticks at its maximum value instead of wrapping, so a
// long-running performance counter never reads back as a small number.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears the count
//   inc    in   count one event on this edge
//   count  out  CNT_W-bit saturating event count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register between decode and execute. Every output is a flop
// output; there is no combinational path from any input to any output.
//
// Edge priority: flush > hold > stall > load.
//   flush : entry becomes a bubble (data/index fields still capture inputs)
//   hold  : every field keeps its value
//   stall : bubble inserted (data/index fields still capture inputs)
//   load  : all fields take the id_* values, ex_valid = 1
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   stall, flush, hold         hazard / branch / downstream-freeze controls
//   id_pc, id_rdata1/2, id_imm XLEN-bit datapath values from decode
//   id_rs1, id_rs2, id_rd      register indices
//   id_funct                   {instr[30], funct3}
//   id_branch .. id_alu_src    control bits, id_alu_op ALU op class
//   ex_*                       registered copies for execute
//   ID_EX_rs1/rs2/rd           registered indices (rd also fed to hazard unit)
//   ID_EX_MemRead              registered MemRead, fed to hazard unit
//   bubble_count, flush_count  saturating performance event counters
// ---------------------------------------------------------------------------
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             hold,

    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic             id_branch,
    input  logic             id_RegWrite,
    input  logic             id_MemtoReg,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_alu_src,
    input  logic [1:0]       id_alu_op,

    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rdata1,
    output logic [XLEN-1:0]  ex_rdata2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic [3:0]       ex_funct,
    output logic             ex_branch,
    output logic             ex_RegWrite,
    output logic             ex_MemtoReg,
    output logic             ID_EX_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_t            id_ctrl;
    ctrl_t            ctrl_p0;
    logic             vld_p0;
    logic [XLEN-1:0]  pc_p0;
    logic [XLEN-1:0]  rdata1_p0;
    logic [XLEN-1:0]  rdata2_p0;
    logic [XLEN-1:0]  imm_p0;
    logic [4:0]       rs1_p0;
    logic [4:0]       rs2_p0;
    logic [4:0]       rd_p0;
    logic [3:0]       funct_p0;

    logic             capture;
    logic             make_bubble;
    logic             bubble_inc;
    logic             flush_inc;

    assign id_ctrl = {id_branch, id_RegWrite, id_MemtoReg, id_MemRead,
                      id_MemWrite, id_alu_src, id_alu_op};

    // Flush wins over hold, so a held entry can still be killed.
    assign capture     = flush | ~hold;
    // Once capturing, either flush or stall turns the new entry into a no-op.
    assign make_bubble = flush | stall;

    // A stall that is masked by hold or flush does not produce a bubble.
    assign bubble_inc = stall & ~flush & ~hold;
    // Only killing a real instruction counts as a flush event.
    assign flush_inc  = flush & vld_p0;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            ctrl_p0   <= BUBBLE_CTRL;
            pc_p0     <= '0;
            rdata1_p0 <= '0;
            rdata2_p0 <= '0;
            imm_p0    <= '0;
            rs1_p0    <= '0;
            rs2_p0    <= '0;
            rd_p0     <= '0;
            funct_p0  <= '0;
        end else if (capture) begin
            pc_p0     <= id_pc;
            rdata1_p0 <= id_rdata1;
            rdata2_p0 <= id_rdata2;
            imm_p0    <= id_imm;
            rs1_p0    <= id_rs1;
            rs2_p0    <= id_rs2;
            funct_p0  <= id_funct;
            if (make_bubble) begin
                // rd is zeroed with the controls so a bubble can never
                // match a source index in the hazard unit.
                vld_p0  <= 1'b0;
                ctrl_p0 <= BUBBLE_CTRL;
                rd_p0   <= '0;
            end else begin
                vld_p0  <= 1'b1;
                ctrl_p0 <= id_ctrl;
                rd_p0   <= id_rd;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign ex_valid      = vld_p0;
    assign ex_pc         = pc_p0;
    assign ex_rdata1     = rdata1_p0;
    assign ex_rdata2     = rdata2_p0;
    assign ex_imm        = imm_p0;
    assign ID_EX_rs1     = rs1_p0;
    assign ID_EX_rs2     = rs2_p0;
    assign ID_EX_rd      = rd_p0;
    assign ex_funct      = funct_p0;
    assign ex_branch     = ctrl_p0.branch;
    assign ex_RegWrite   = ctrl_p0.reg_write;
    assign ex_MemtoReg   = ctrl_p0.memto_reg;
    assign ID_EX_MemRead = ctrl_p0.mem_read;
    assign ex_MemWrite   = ctrl_p0.mem_write;
    assign ex_alu_src    = ctrl_p0.alu_src;
    assign ex_alu_op     = ctrl_p0.alu_op;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset, stall, flush, hold;
    logic [XLEN-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [3:0] id_funct;
    logic id_branch, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_alu_src;
    logic [1:0] id_alu_op;

    logic ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [3:0] ex_funct;
    logic ex_branch, ex_RegWrite, ex_MemtoReg, ID_EX_MemRead, ex_MemWrite, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic [CNT_W-1:0] bubble_count, flush_count;

    // second instance with 2-bit counters for saturation checks
    logic d2_valid;
    logic [XLEN-1:0] d2_pc, d2_rdata1, d2_rdata2, d2_imm;
    logic [4:0] d2_rs1, d2_rs2, d2_rd;
    logic [3:0] d2_funct;
    logic d2_branch, d2_rw, d2_m2r, d2_mr, d2_mw, d2_asrc;
    logic [1:0] d2_aop;
    logic [1:0] d2_bubble, d2_flush;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .hold(hold),
        .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_branch(id_branch), .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ex_funct(ex_funct), .ex_branch(ex_branch), .ex_RegWrite(ex_RegWrite),
        .ex_MemtoReg(ex_MemtoReg), .ID_EX_MemRead(ID_EX_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .hold(hold),
        .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_branch(id_branch), .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op),
        .ex_valid(d2_valid), .ex_pc(d2_pc), .ex_rdata1(d2_rdata1), .ex_rdata2(d2_rdata2),
        .ex_imm(d2_imm), .ID_EX_rs1(d2_rs1), .ID_EX_rs2(d2_rs2), .ID_EX_rd(d2_rd),
        .ex_funct(d2_funct), .ex_branch(d2_branch), .ex_RegWrite(d2_rw),
        .ex_MemtoReg(d2_m2r), .ID_EX_MemRead(d2_mr), .ex_MemWrite(d2_mw),
        .ex_alu_src(d2_asrc), .ex_alu_op(d2_aop),
        .bubble_count(d2_bubble), .flush_count(d2_flush)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the execute stage should currently see
    // ------------------------------------------------------------------
    typedef struct {
        bit              valid;
        bit              data_known;  // data fields are don't-care after a flush
        logic [XLEN-1:0] pc, r1, r2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      funct;
        bit              branch, rw, m2r, mr, mw, asrc;
        logic [1:0]      aop;
        int              bub, fl, bub2, fl2;
    } model_t;

    model_t m;

    function automatic int sat_add(input int v, input int w);
        return (v < (1 << w) - 1) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m.data_known = 1'b1;
    endtask

    task automatic model_edge();
        bit real_instr;
        if (flush && m.valid) begin
            m.fl  = sat_add(m.fl, CNT_W);
            m.fl2 = sat_add(m.fl2, 2);
        end
        if (stall && !flush && !hold) begin
            m.bub  = sat_add(m.bub, CNT_W);
            m.bub2 = sat_add(m.bub2, 2);
        end
        if (flush || !hold) begin
            real_instr   = !flush && !stall;
            m.data_known = !flush;
            m.pc  = id_pc;  m.r1  = id_rdata1; m.r2 = id_rdata2; m.imm = id_imm;
            m.rs1 = id_rs1; m.rs2 = id_rs2;    m.funct = id_funct;
            m.valid  = real_instr;
            m.rd     = real_instr ? id_rd : 5'd0;
            m.branch = real_instr & id_branch;
            m.rw     = real_instr & id_RegWrite;
            m.m2r    = real_instr & id_MemtoReg;
            m.mr     = real_instr & id_MemRead;
            m.mw     = real_instr & id_MemWrite;
            m.asrc   = real_instr & id_alu_src;
            m.aop    = real_instr ? id_alu_op : 2'b00;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"},   64'(ex_valid),      64'(m.valid));
        chk({tag, ".rd"},      64'(ID_EX_rd),      64'(m.rd));
        chk({tag, ".branch"},  64'(ex_branch),     64'(m.branch));
        chk({tag, ".regwr"},   64'(ex_RegWrite),   64'(m.rw));
        if (m.rw) chk({tag, ".memtoreg"}, 64'(ex_MemtoReg), 64'(m.m2r));
        chk({tag, ".memrd"},   64'(ID_EX_MemRead), 64'(m.mr));
        chk({tag, ".memwr"},   64'(ex_MemWrite),   64'(m.mw));
        chk({tag, ".alusrc"},  64'(ex_alu_src),    64'(m.asrc));
        chk({tag, ".aluop"},   64'(ex_alu_op),     64'(m.aop));
        chk({tag, ".bubcnt"},  64'(bubble_count),  64'(m.bub));
        chk({tag, ".flcnt"},   64'(flush_count),   64'(m.fl));
        chk({tag, ".bubcnt2"}, 64'(d2_bubble),     64'(m.bub2));
        chk({tag, ".flcnt2"},  64'(d2_flush),      64'(m.fl2));
        if (m.data_known) begin
            chk({tag, ".pc"},    ex_pc,              m.pc);
            chk({tag, ".r1"},    ex_rdata1,          m.r1);
            chk({tag, ".r2"},    ex_rdata2,          m.r2);
            chk({tag, ".imm"},   ex_imm,             m.imm);
            chk({tag, ".rs1"},   64'(ID_EX_rs1),     64'(m.rs1));
            chk({tag, ".rs2"},   64'(ID_EX_rs2),     64'(m.rs2));
            chk({tag, ".funct"}, 64'(ex_funct),      64'(m.funct));
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; hold = 0;
        id_pc = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct = '0;
        id_branch = 0; id_RegWrite = 0; id_MemtoReg = 0; id_MemRead = 0;
        id_MemWrite = 0; id_alu_src = 0; id_alu_op = '0;
    endtask

    task automatic rand_inputs();
        flush = ($urandom_range(0, 9) == 0);
        hold  = ($urandom_range(0, 6) == 0);
        stall = ($urandom_range(0, 4) == 0);
        id_pc     = {$urandom, $urandom};
        id_rdata1 = {$urandom, $urandom};
        id_rdata2 = {$urandom, $urandom};
        id_imm    = {$urandom, $urandom};
        id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
        id_funct = 4'($urandom);
        {id_branch, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_alu_src} = 6'($urandom);
        id_alu_op = 2'($urandom_range(0, 2));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        bit          flush, hold, stall;
        logic [4:0]  rd, rs1;
        logic [63:0] imm;
        bit          mr, rw;
        logic [1:0]  aop;
        bit          e_valid;
        logic [4:0]  e_rd;
        bit          e_mr, e_rw;
        logic [1:0]  e_aop;
        bit          chk_imm;
        logic [63:0] e_imm;
        int          e_bub, e_fl;
    } vec_t;

    vec_t tbl[10];

    initial begin
        //          name        fl ho st rd  rs1 imm  mr rw aop   | val rd  mr rw aop  ci imm  bub fl
        tbl[0] = '{"ld_x5",     0, 0, 0, 5,  2,  8,   1, 1, 2'b00, 1, 5,  1, 1, 2'b00, 1, 8,   0, 0};
        tbl[1] = '{"add_stall", 0, 0, 1, 6,  5,  0,   0, 1, 2'b10, 0, 0,  0, 0, 2'b00, 1, 0,   1, 0};
        tbl[2] = '{"add_load",  0, 0, 0, 6,  5,  0,   0, 1, 2'b10, 1, 6,  0, 1, 2'b10, 1, 0,   1, 0};
        tbl[3] = '{"flush_hold",1, 1, 1, 7,  1,  3,   1, 1, 2'b10, 0, 0,  0, 0, 2'b00, 0, 0,   1, 1};
        tbl[4] = '{"flush_bub", 1, 0, 0, 7,  1,  3,   1, 1, 2'b10, 0, 0,  0, 0, 2'b00, 0, 0,   1, 1};
        tbl[5] = '{"load_x9",   0, 0, 0, 9,  3,  16,  0, 1, 2'b10, 1, 9,  0, 1, 2'b10, 1, 16,  1, 1};
        tbl[6] = '{"hold1",     0, 1, 1, 10, 4,  100, 1, 0, 2'b01, 1, 9,  0, 1, 2'b10, 1, 16,  1, 1};
        tbl[7] = '{"hold2",     0, 1, 1, 11, 5,  101, 0, 0, 2'b00, 1, 9,  0, 1, 2'b10, 1, 16,  1, 1};
        tbl[8] = '{"hold3",     0, 1, 1, 12, 6,  102, 1, 1, 2'b01, 1, 9,  0, 1, 2'b10, 1, 16,  1, 1};
        tbl[9] = '{"release",   0, 0, 0, 13, 7,  200, 1, 0, 2'b00, 1, 13, 1, 0, 2'b00, 1, 200, 1, 1};
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        #3;
        model_reset();
        check_state("reset");
        @(posedge clk);
        #2 reset = 1'b0;

        // directed table
        for (int i = 0; i < 10; i++) begin
            flush = tbl[i].flush; hold = tbl[i].hold; stall = tbl[i].stall;
            id_rd = tbl[i].rd; id_rs1 = tbl[i].rs1; id_imm = tbl[i].imm;
            id_MemRead = tbl[i].mr; id_RegWrite = tbl[i].rw; id_alu_op = tbl[i].aop;
            @(posedge clk);
            #1;
            chk({tbl[i].name, ".valid"}, 64'(ex_valid),      64'(tbl[i].e_valid));
            chk({tbl[i].name, ".rd"},    64'(ID_EX_rd),      64'(tbl[i].e_rd));
            chk({tbl[i].name, ".memrd"}, 64'(ID_EX_MemRead), 64'(tbl[i].e_mr));
            chk({tbl[i].name, ".regwr"}, 64'(ex_RegWrite),   64'(tbl[i].e_rw));
            chk({tbl[i].name, ".aluop"}, 64'(ex_alu_op),     64'(tbl[i].e_aop));
            chk({tbl[i].name, ".bub"},   64'(bubble_count),  64'(tbl[i].e_bub));
            chk({tbl[i].name, ".fl"},    64'(flush_count),   64'(tbl[i].e_fl));
            if (tbl[i].chk_imm)
                chk({tbl[i].name, ".imm"}, ex_imm, tbl[i].e_imm);
        end

        // asynchronous reset mid-cycle with a valid entry resident
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_state("async_reset");
        @(posedge clk);
        #1;
        check_state("reset_over_edge");
        #1 reset = 1'b0;

        // saturation: stall held 6 cycles, 2-bit counter sticks at 3
        clear_inputs();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) cyc($sformatf("sat%0d", i));
        chk("sat_final.bubcnt2", 64'(d2_bubble), 64'd3);
        chk("sat_final.bubcnt", 64'(bubble_count), 64'd6);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cyc($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register. It sits between decode and execute, and receives the stall and gated control bits from the hazard detection unit.
- It captures operands, immediates, register indices and control bits each cycle.
- It inserts a bubble on stall, kills the entry on a branch flush, and freezes on a downstream hold.
- It feeds ID_EX_rd and ID_EX_MemRead back to the hazard unit, and keeps saturating bubble/flush event counters for performance debug.

Parameters:
- XLEN, 64, datapath width for pc, operands and immediate.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  load-use stall from hazard unit; inserts a bubble
- flush  in  1  taken branch resolved downstream; kill the entry being captured
- hold  in  1  downstream freeze; retain all current contents
- id_pc  in  XLEN  PC of the decode instruction
- id_rdata1, id_rdata2  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct  in  4  {instr[30], funct3} for ALU control
- id_branch, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_alu_src  in  1 each  control bits
- id_alu_op  in  2  ALU op class
- ex_valid  out  1  entry holds a real instruction
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  XLEN  registered copies
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5  registered indices
- ex_funct  out  4
- ex_branch, ex_RegWrite, ex_MemtoReg, ID_EX_MemRead, ex_MemWrite, ex_alu_src  out  1 each
- ex_alu_op  out  2
- bubble_count  out  CNT_W  number of bubbles inserted
- flush_count  out  CNT_W  number of valid entries killed

Behaviour:
- Reset (async, immediate):
  - every output goes to 0, including ex_valid and both counters;
  - the register then holds a bubble.
- Each rising edge evaluates in strict priority: flush > hold > stall > load.
- flush=1:
  - the entry becomes a bubble: ex_valid=0, all six control bits 0, ex_alu_op=00, ID_EX_rd=0;
  - data and index fields load from inputs, value don't-care, but must be deterministic;
  - flush overrides hold and stall in the same cycle.
- hold=1 (flush=0): every output is unchanged. stall is ignored, because the hazard unit re-asserts it while the condition persists.
- stall=1 (flush=0, hold=0):
  - bubble inserted: ex_valid=0, controls 0, ex_alu_op=00, ID_EX_rd=0;
  - index/data fields still load from inputs.
- Otherwise (load):
  - all fields take the id_* values;
  - ex_valid=1;
  - MemtoReg is captured as presented. An X from decode passes through; benches must mask it unless RegWrite=1.
- Feedback:
  - ID_EX_MemRead and ID_EX_rd are plain flop outputs with no combinational path from inputs;
  - both are 0 whenever ex_valid=0, so a bubble never triggers a second stall.
- Latency: one cycle from id_* to outputs. There is no combinational input-to-output path on any port.
- Counters:
  - bubble_count increments on an edge where stall=1, flush=0, hold=0;
  - flush_count increments on an edge where flush=1 and the current ex_valid=1;
  - both saturate at 2^CNT_W−1; no wrap;
  - counters are not affected by hold.
- Reset mid-stall or mid-hold: outputs clear immediately. The first edge after reset deasserts evaluates normally.

Decomposition:
- Shared pipeline package holds:
  - the opcode constants already used by control (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011);
  - alu_op encodings 00/01/10;
  - a packed control-bundle typedef {branch, RegWrite, MemtoReg, MemRead, MemWrite, alu_src, alu_op[1:0]};
  - a BUBBLE_CTRL constant of all zeros.
- One sub-module is natural: sat_counter (parameter CNT_W; inputs clk, reset, inc; output count), instantiated twice.

Test Plan:
- Reset asserted mid-cycle with the entry loaded -> all outputs 0 immediately, before the next edge.
- Load ld x5,8(x2): id_MemRead=1, id_RegWrite=1, id_rd=5, id_imm=8 -> next edge ex_valid=1, ID_EX_MemRead=1, ID_EX_rd=5, ex_imm=8.
- Following add x6,x5,x1 with stall=1 for one cycle -> next edge ex_valid=0, ID_EX_MemRead=0, ID_EX_rd=0, bubble_count=1. Next edge with stall=0 -> add loads, ex_RegWrite=1, ex_alu_op=10.
- Valid entry resident, flush=1 and hold=1 together -> entry killed (ex_valid=0, controls 0), flush_count=1. Repeat with ex_valid=0 -> flush_count stays 1.
- hold=1 for 3 cycles with stall=1 and changing id_* -> outputs frozen, bubble_count unchanged. Release -> new values load.
- CNT_W=2, stall held 6 cycles -> bubble_count reaches 3 and stays 3.
